z88_mem_arbiter: RTL and testbench

- Shares the single external 512 KB SRAM between two requesters: the Z80 CPU port and the LCD screen-fetch DMA port.
- Sequences every SRAM access: chip-enable, output-enable and write strobes, address and data latching.
- Stalls the CPU through wait_n while the SRAM is busy.
- Sits between the Z80 memory-decode logic (which has already resolved the 19-bit physical RAM address) and the SRAM pins.

---
 rtl/z88_pkg.sv | 15 +
 rtl/z88_sram_seq.sv | 95 +++++++++
 rtl/z88_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_z88_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z88_pkg.sv
// Shared types and widths for the Z88 SRAM arbiter: arbiter state encoding
// and the physical RAM address/data widths.
package z88_pkg;

    localparam int RAM_AW = 19;
    localparam int RAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        LCD_ACC = 2'd2,
        RECOVER = 2'd3
    } arb_state_e;

endpackage

// File: rtl/z88_sram_seq.sv
// Single-access SRAM strobe sequencer: latches one request on start_i and
// drives registered CE/OE/WE strobes for ACC_CYCLES cycles.
module z88_sram_seq
    import z88_pkg::*;
#(
    parameter int ACC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [RAM_AW-1:0] addr_i,
    input  logic [RAM_DW-1:0] wdata_i,
    output logic              done_o,
    output logic              rd_done_o,
    output logic [RAM_DW-1:0] rdata_o,
    output logic [RAM_AW-1:0] ram_a_o,
    output logic [RAM_DW-1:0] ram_do_o,
    input  logic [RAM_DW-1:0] ram_di_i,
    output logic              ram_ce_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o
);

    localparam logic [3:0] LAST_CYC = 4'(ACC_CYCLES - 1);

    logic              active_q, active_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [RAM_DW-1:0] data_q, data_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              last_cyc;

    assign last_cyc = active_q && (cnt_q == LAST_CYC);

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = 4'd0;
            we_d     = we_i;
            addr_d   = addr_i;
            data_d   = wdata_i;
        end else if (last_cyc) begin
            active_d = 1'b0;
            cnt_d    = 4'd0;
        end else if (active_q) begin
            cnt_d = cnt_q + 4'd1;
        end
        // Strobes come straight from flops so the SRAM never sees a glitch;
        // the first write cycle is address setup with WE still high.
        ce_n_d = ~active_d;
        oe_n_d = ~(active_d & ~we_d);
        we_n_d = ~(active_d & we_d & (cnt_d != 4'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
        end
    end

    assign done_o     = last_cyc;
    assign rd_done_o  = last_cyc & ~we_q;
    assign rdata_o    = ram_di_i;
    assign ram_a_o    = addr_q;
    assign ram_do_o   = data_q;
    assign ram_ce_n_o = ce_n_q;
    assign ram_oe_n_o = oe_n_q;
    assign ram_we_n_o = we_n_q;

endmodule

// File: rtl/z88_mem_arbiter.sv
// Arbitrates the 512 KB SRAM between the Z80 CPU and the LCD fetch DMA.
// Define MEMARB_FAIRNESS_EN to bound CPU bursts while the LCD is pending.
module z88_mem_arbiter
    import z88_pkg::*;
#(
    parameter int ACC_CYCLES    = 2,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [RAM_AW-1:0] cpu_a,
    input  logic [RAM_DW-1:0] cpu_do,
    output logic [RAM_DW-1:0] cpu_di,
    output logic              cpu_ack,
    output logic              cpu_wait_n,
    input  logic              lcd_req,
    input  logic [RAM_AW-1:0] lcd_a,
    output logic [RAM_DW-1:0] lcd_di,
    output logic              lcd_ack,
    output logic [RAM_AW-1:0] ram_a,
    output logic [RAM_DW-1:0] ram_do,
    input  logic [RAM_DW-1:0] ram_di,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    arb_state_e        state_q, state_d;
    logic [RAM_DW-1:0] cpu_di_q, cpu_di_d;
    logic [RAM_DW-1:0] lcd_di_q, lcd_di_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              lcd_ack_q, lcd_ack_d;

    logic              in_idle;
    logic              force_lcd;
    logic              grant_cpu;
    logic              grant_lcd;
    logic              seq_start;
    logic              seq_we;
    logic [RAM_AW-1:0] seq_addr;
    logic [RAM_DW-1:0] seq_wdata;
    logic              seq_done;
    logic              seq_rd_done;
    logic [RAM_DW-1:0] seq_rdata;

    assign in_idle   = (state_q == IDLE);
    assign grant_cpu = in_idle & cpu_req & ~force_lcd;
    assign grant_lcd = in_idle & lcd_req & ~grant_cpu;

    assign seq_start = grant_cpu | grant_lcd;
    assign seq_we    = grant_cpu & cpu_we;
    assign seq_addr  = grant_cpu ? cpu_a : lcd_a;
    assign seq_wdata = grant_cpu ? cpu_do : '0;

`ifdef MEMARB_FAIRNESS_EN
    logic [7:0] burst_q, burst_d;

    // Counts CPU grants taken while the LCD was waiting; at the limit the
    // LCD is granted ahead of a pending CPU request.
    assign force_lcd = lcd_req && (burst_q == 8'(MAX_CPU_BURST));

    always_comb begin
        burst_d = burst_q;
        if (grant_cpu) begin
            burst_d = lcd_req ? burst_q + 8'd1 : 8'd0;
        end else if (grant_lcd) begin
            burst_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_q <= 8'd0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    logic unused_max_burst;

    assign unused_max_burst = ^8'(MAX_CPU_BURST);
    assign force_lcd        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cpu_ack_d = 1'b0;
        lcd_ack_d = 1'b0;
        cpu_di_d  = cpu_di_q;
        lcd_di_d  = lcd_di_q;
        case (state_q)
            IDLE: begin
                if (grant_cpu) begin
                    state_d = CPU_ACC;
                end else if (grant_lcd) begin
                    state_d = LCD_ACC;
                end
            end
            CPU_ACC: begin
                if (seq_done) begin
                    state_d   = RECOVER;
                    cpu_ack_d = 1'b1;
                    if (seq_rd_done) begin
                        cpu_di_d = seq_rdata;
                    end
                end
            end
            LCD_ACC: begin
                if (seq_done) begin
                    state_d   = RECOVER;
                    lcd_ack_d = 1'b1;
                    lcd_di_d  = seq_rdata;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cpu_di_q  <= '0;
            lcd_di_q  <= '0;
            cpu_ack_q <= 1'b0;
            lcd_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_di_q  <= cpu_di_d;
            lcd_di_q  <= lcd_di_d;
            cpu_ack_q <= cpu_ack_d;
            lcd_ack_q <= lcd_ack_d;
        end
    end

    z88_sram_seq #(
        .ACC_CYCLES (ACC_CYCLES)
    ) u_seq (
        .clk        (clk),
        .rst_n      (reset_n),
        .start_i    (seq_start),
        .we_i       (seq_we),
        .addr_i     (seq_addr),
        .wdata_i    (seq_wdata),
        .done_o     (seq_done),
        .rd_done_o  (seq_rd_done),
        .rdata_o    (seq_rdata),
        .ram_a_o    (ram_a),
        .ram_do_o   (ram_do),
        .ram_di_i   (ram_di),
        .ram_ce_n_o (ram_ce_n),
        .ram_oe_n_o (ram_oe_n),
        .ram_we_n_o (ram_we_n)
    );

    assign cpu_di     = cpu_di_q;
    assign lcd_di     = lcd_di_q;
    assign cpu_ack    = cpu_ack_q;
    assign lcd_ack    = lcd_ack_q;
    // The CPU stalls from request until its ack cycle.
    assign cpu_wait_n = ~(cpu_req & ~cpu_ack_q);

endmodule

// File: tb/tb_z88_mem_arbiter.sv
// Self-checking bench for z88_mem_arbiter: directed steps plus randomized
// transactions checked against a transaction-level SRAM/arbitration model.
module tb_z88_mem_arbiter;

    localparam int ACC   = 2;
    localparam int MAXB  = 4;
    localparam int BUS_W = 29;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [18:0] cpu_a = '0;
    logic [7:0]  cpu_do = '0;
    logic [7:0]  cpu_di;
    logic        cpu_ack;
    logic        cpu_wait_n;
    logic        lcd_req = 1'b0;
    logic [18:0] lcd_a = '0;
    logic [7:0]  lcd_di;
    logic        lcd_ack;
    logic [18:0] ram_a;
    logic [7:0]  ram_do;
    logic [7:0]  ram_di = '0;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit mon_en = 0;
    bit sb_en = 0;

    // Expected bus words per access cycle: {addr, write data or 0, oe_n, we_n}
    logic [BUS_W-1:0] exp_q[$];
    logic [7:0] exp_mem[logic [18:0]];
    logic [7:0] sram[logic [18:0]];

    z88_mem_arbiter #(
        .ACC_CYCLES    (ACC),
        .MAX_CPU_BURST (MAXB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_a      (cpu_a),
        .cpu_do     (cpu_do),
        .cpu_di     (cpu_di),
        .cpu_ack    (cpu_ack),
        .cpu_wait_n (cpu_wait_n),
        .lcd_req    (lcd_req),
        .lcd_a      (lcd_a),
        .lcd_di     (lcd_di),
        .lcd_ack    (lcd_ack),
        .ram_a      (ram_a),
        .ram_do     (ram_do),
        .ram_di     (ram_di),
        .ram_ce_n   (ram_ce_n),
        .ram_oe_n   (ram_oe_n),
        .ram_we_n   (ram_we_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] dflt(input logic [18:0] a);
        return a[7:0] ^ {a[18:16], a[12:8]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] exp_read(input logic [18:0] a);
        if (exp_mem.exists(a)) return exp_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [7:0] sram_rd(input logic [18:0] a);
        if (sram.exists(a)) return sram[a];
        return dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Behavioural SRAM on the pins
    always @(posedge clk) begin
        if (reset_n && !ram_ce_n && !ram_we_n) sram[ram_a] = ram_do;
    end

    always @(negedge clk) begin
        ram_di = (!ram_ce_n && !ram_oe_n) ? sram_rd(ram_a) : 8'h00;
    end

    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            chk("ack_overlap", 32'(cpu_ack & lcd_ack), 32'd0);
            chk("wait_n", 32'(cpu_wait_n), 32'(!(cpu_req && !cpu_ack)));
            chk("oe_we_both_low", 32'(!ram_oe_n && !ram_we_n), 32'd0);
            if (sb_en && !ram_ce_n) begin
                if (exp_q.size() == 0) begin
                    chk("bus_unexpected_access", 32'(ram_a), 32'h7FFFFFFF);
                end else begin
                    logic [BUS_W-1:0] w;
                    w = exp_q.pop_front();
                    chk("bus_cycle", 32'({ram_a, (ram_oe_n ? ram_do : 8'h00), ram_oe_n, ram_we_n}), 32'(w));
                end
            end
        end
    end

    task automatic run_txn(input bit cpu_en, input bit lcd_en, input bit wr,
                           input logic [18:0] ca, input logic [7:0] cd, input logic [18:0] la);
        int c0;
        int exp_c;
        int exp_l;
        int n;
        bit cdone;
        bit ldone;
        logic [7:0] exp_cd;
        logic [7:0] exp_ld;
        cdone = !cpu_en;
        ldone = !lcd_en;
        exp_c = -1;
        exp_l = -1;
        exp_cd = exp_read(ca);
        if (cpu_en) begin
            for (int k = 0; k < ACC; k++) exp_q.push_back({ca, (wr ? cd : 8'h00), wr, !(wr && k > 0)});
            if (wr) exp_mem[ca] = cd;
        end
        exp_ld = exp_read(la);
        if (lcd_en) begin
            for (int k = 0; k < ACC; k++) exp_q.push_back({la, 8'h00, 1'b0, 1'b1});
        end
        @(negedge clk);
        c0 = cyc;
        if (cpu_en) exp_c = c0 + ACC + 1;
        if (lcd_en) exp_l = cpu_en ? c0 + 2 * ACC + 3 : c0 + ACC + 1;
        cpu_req = cpu_en;
        cpu_we  = wr;
        cpu_a   = ca;
        cpu_do  = cd;
        lcd_req = lcd_en;
        lcd_a   = la;
        n = 0;
        while (!(cdone && ldone) && n < 40) begin
            @(negedge clk);
            n++;
            if (cpu_ack) begin
                chk("cpu_ack_cycle", 32'(cyc), 32'(exp_c));
                if (!wr) chk("cpu_di", 32'(cpu_di), 32'(exp_cd));
                cpu_req = 1'b0;
                cdone = 1'b1;
            end
            if (lcd_ack) begin
                chk("lcd_ack_cycle", 32'(cyc), 32'(exp_l));
                chk("lcd_di", 32'(lcd_di), 32'(exp_ld));
                lcd_req = 1'b0;
                ldone = 1'b1;
            end
            // Granted port's inputs wander mid-access; the latched values must hold
            if (cpu_req) begin
                cpu_a  = 19'($urandom);
                cpu_do = 8'($urandom);
                cpu_we = 1'($urandom);
            end
            if (lcd_req && !cpu_en) lcd_a = 19'($urandom);
        end
        chk("txn_complete", 32'(cdone && ldone), 32'd1);
        chk("bus_words_left", 32'(exp_q.size()), 32'd0);
        cpu_req = 1'b0;
        lcd_req = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int n;
        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ce_n", 32'(ram_ce_n), 32'd1);
        chk("rst_oe_n", 32'(ram_oe_n), 32'd1);
        chk("rst_we_n", 32'(ram_we_n), 32'd1);
        chk("rst_ram_a", 32'(ram_a), 32'd0);
        chk("rst_ram_do", 32'(ram_do), 32'd0);
        chk("rst_cpu_di", 32'(cpu_di), 32'd0);
        chk("rst_lcd_di", 32'(lcd_di), 32'd0);
        chk("rst_acks", 32'({cpu_ack, lcd_ack}), 32'd0);
        chk("rst_wait_n", 32'(cpu_wait_n), 32'd1);
        reset_n = 1'b1;
        mon_en = 1'b1;
        sb_en = 1'b1;

        // Directed: read with preloaded A5, write to top address, read back, contention
        sram[19'h00123] = 8'hA5;
        exp_mem[19'h00123] = 8'hA5;
        run_txn(1, 0, 0, 19'h00123, 8'h00, 19'h0);
        run_txn(1, 0, 1, 19'h7FFFF, 8'h3C, 19'h0);
        run_txn(1, 0, 0, 19'h7FFFF, 8'h00, 19'h0);
        run_txn(0, 1, 0, 19'h0, 8'h00, 19'h7FFFF);
        run_txn(1, 1, 0, 19'h00123, 8'h00, 19'h7FFFF);
        run_txn(1, 1, 1, 19'h00200, 8'hE7, 19'h00200);

        // Randomized traffic over a small address window so locations repeat
        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [18:0] ca;
            logic [18:0] la;
            kind = $urandom_range(0, 2);
            ca = 19'h40000 + 19'($urandom_range(0, 15));
            la = 19'h40000 + 19'($urandom_range(0, 15));
            run_txn(kind != 1, kind != 0, 1'($urandom), ca, 8'($urandom), la);
        end

        // Reset in the middle of a write's strobe cycle
        sb_en = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we  = 1'b1;
        cpu_a   = 19'h2AAAA;
        cpu_do  = 8'h99;
        @(negedge clk);
        chk("rstw_setup_ce_n", 32'(ram_ce_n), 32'd0);
        chk("rstw_setup_we_n", 32'(ram_we_n), 32'd1);
        @(negedge clk);
        chk("rstw_strobe_we_n", 32'(ram_we_n), 32'd0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rstw_ce_n", 32'(ram_ce_n), 32'd1);
        chk("rstw_oe_n", 32'(ram_oe_n), 32'd1);
        chk("rstw_we_n", 32'(ram_we_n), 32'd1);
        chk("rstw_ram_a", 32'(ram_a), 32'd0);
        chk("rstw_ram_do", 32'(ram_do), 32'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rstw_no_ack", 32'({cpu_ack, lcd_ack}), 32'd0);
            chk("rstw_idle_ce_n", 32'(ram_ce_n), 32'd1);
        end
        sb_en = 1'b1;
        run_txn(1, 0, 0, 19'h00123, 8'h00, 19'h0);

        // Continuous contention: grant order
        sb_en = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_a   = 19'h00123;
        lcd_req = 1'b1;
        lcd_a   = 19'h01000;
        acks = 0;
        n = 0;
        while (acks < 10 && n < 200) begin
            @(negedge clk);
            n++;
            if (cpu_ack || lcd_ack) begin
`ifdef MEMARB_FAIRNESS_EN
                chk("grant_order_lcd", 32'(lcd_ack), 32'((acks % (MAXB + 1)) == MAXB));
`else
                chk("grant_order_lcd", 32'(lcd_ack), 32'd0);
`endif
                acks++;
            end
        end
        chk("grant_order_count", 32'(acks), 32'd10);
        cpu_req = 1'b0;
        lcd_req = 1'b0;
        repeat (ACC + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
